// File: rtl/gsu_mem_arbiter_if.sv
// rtl/gsu_mem_arbiter_if.sv - requester and memory port bundle for the GSU memory arbiter
interface gsu_mem_arbiter_if;
  logic        SNES_REQ;
  logic [23:0] SNES_ADDR;
  logic        SNES_WE;
  logic [7:0]  SNES_WDATA;
  logic [7:0]  SNES_RDATA;
  logic        SNES_ACK;

  logic        GSU_REQ;
  logic [23:0] GSU_ADDR;
  logic        GSU_WE;
  logic [7:0]  GSU_WDATA;
  logic [7:0]  GSU_RDATA;
  logic        GSU_ACK;

  logic        MCU_REQ;
  logic [23:0] MCU_ADDR;
  logic        MCU_WE;
  logic [7:0]  MCU_WDATA;
  logic [7:0]  MCU_RDATA;
  logic        MCU_ACK;

  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_DOUT;
  logic        MEM_DRIVE;
  logic        MEM_OE_N;
  logic        MEM_WE_N;
  logic [7:0]  MEM_DIN;

  logic        BUSY;
  logic        SNES_OVERRUN;

  // Arbiter side: takes requests and memory read data, drives responses and strobes.
  modport slave (
    input  SNES_REQ, SNES_ADDR, SNES_WE, SNES_WDATA,
    output SNES_RDATA, SNES_ACK,
    input  GSU_REQ, GSU_ADDR, GSU_WE, GSU_WDATA,
    output GSU_RDATA, GSU_ACK,
    input  MCU_REQ, MCU_ADDR, MCU_WE, MCU_WDATA,
    output MCU_RDATA, MCU_ACK,
    output MEM_ADDR, MEM_DOUT, MEM_DRIVE, MEM_OE_N, MEM_WE_N,
    input  MEM_DIN,
    output BUSY, SNES_OVERRUN
  );

  // Requester/memory side: the mirror image of the arbiter.
  modport master (
    output SNES_REQ, SNES_ADDR, SNES_WE, SNES_WDATA,
    input  SNES_RDATA, SNES_ACK,
    output GSU_REQ, GSU_ADDR, GSU_WE, GSU_WDATA,
    input  GSU_RDATA, GSU_ACK,
    output MCU_REQ, MCU_ADDR, MCU_WE, MCU_WDATA,
    input  MCU_RDATA, MCU_ACK,
    input  MEM_ADDR, MEM_DOUT, MEM_DRIVE, MEM_OE_N, MEM_WE_N,
    output MEM_DIN,
    input  BUSY, SNES_OVERRUN
  );
endinterface

// File: rtl/gsu_mem_arbiter.sv
// rtl/gsu_mem_arbiter.sv - single-port ROM/SaveRAM arbiter for SNES, GSU and MCU
module gsu_mem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 6
) (
  input  logic               CLK,
  input  logic               RST_N,
  gsu_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_SNES = 2'd1,
    GNT_GSU  = 2'd2,
    GNT_MCU  = 2'd3
  } gnt_t;

  // cnt counts ACCESS cycles down to 0; write strobe spans CNT_WE_HI..1
  // so the first and last ACCESS cycles give address/data setup and hold.
  localparam logic [3:0] CNT_LOAD  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] CNT_WE_HI = 4'(ACCESS_CYCLES - 2);

  state_t      state_q, state_d;
  gnt_t        gnt_q, gnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rr_mcu_q, rr_mcu_d;

  logic        snes_pend_q, snes_pend_d;
  logic [23:0] snes_addr_q, snes_addr_d;
  logic        snes_we_q, snes_we_d;
  logic [7:0]  snes_wdata_q, snes_wdata_d;
  logic        snes_overrun_q, snes_overrun_d;

  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_drive_q, mem_drive_d;
  logic        mem_oe_n_q, mem_oe_n_d;
  logic        mem_we_n_q, mem_we_n_d;

  logic        snes_ack_q, snes_ack_d;
  logic        gsu_ack_q, gsu_ack_d;
  logic        mcu_ack_q, mcu_ack_d;
  logic [7:0]  snes_rdata_q, snes_rdata_d;
  logic [7:0]  gsu_rdata_q, gsu_rdata_d;
  logic [7:0]  mcu_rdata_q, mcu_rdata_d;
  logic        busy_q, busy_d;

  logic        snes_serving;
  logic        win_valid;
  gnt_t        win_gnt;
  logic [23:0] win_addr;
  logic        win_we;
  logic [7:0]  win_wdata;

  // State, grant, SNES latch and all registered outputs; reset aborts any access.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      gnt_q          <= GNT_NONE;
      cnt_q          <= 4'd0;
      rr_mcu_q       <= 1'b0;
      snes_pend_q    <= 1'b0;
      snes_addr_q    <= 24'd0;
      snes_we_q      <= 1'b0;
      snes_wdata_q   <= 8'd0;
      snes_overrun_q <= 1'b0;
      mem_addr_q     <= 24'd0;
      mem_dout_q     <= 8'd0;
      mem_we_q       <= 1'b0;
      mem_drive_q    <= 1'b0;
      mem_oe_n_q     <= 1'b1;
      mem_we_n_q     <= 1'b1;
      snes_ack_q     <= 1'b0;
      gsu_ack_q      <= 1'b0;
      mcu_ack_q      <= 1'b0;
      snes_rdata_q   <= 8'd0;
      gsu_rdata_q    <= 8'd0;
      mcu_rdata_q    <= 8'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      cnt_q          <= cnt_d;
      rr_mcu_q       <= rr_mcu_d;
      snes_pend_q    <= snes_pend_d;
      snes_addr_q    <= snes_addr_d;
      snes_we_q      <= snes_we_d;
      snes_wdata_q   <= snes_wdata_d;
      snes_overrun_q <= snes_overrun_d;
      mem_addr_q     <= mem_addr_d;
      mem_dout_q     <= mem_dout_d;
      mem_we_q       <= mem_we_d;
      mem_drive_q    <= mem_drive_d;
      mem_oe_n_q     <= mem_oe_n_d;
      mem_we_n_q     <= mem_we_n_d;
      snes_ack_q     <= snes_ack_d;
      gsu_ack_q      <= gsu_ack_d;
      mcu_ack_q      <= mcu_ack_d;
      snes_rdata_q   <= snes_rdata_d;
      gsu_rdata_q    <= gsu_rdata_d;
      mcu_rdata_q    <= mcu_rdata_d;
      busy_q         <= busy_d;
    end
  end

  // Arbitration winner for an IDLE cycle: SNES (latched or same-cycle pulse), then round-robin.
  always_comb begin
    win_valid = 1'b0;
    win_gnt   = GNT_NONE;
    win_addr  = 24'd0;
    win_we    = 1'b0;
    win_wdata = 8'd0;
    if (snes_pend_q) begin
      win_valid = 1'b1;
      win_gnt   = GNT_SNES;
      win_addr  = snes_addr_q;
      win_we    = snes_we_q;
      win_wdata = snes_wdata_q;
    end else if (bus.SNES_REQ) begin
      win_valid = 1'b1;
      win_gnt   = GNT_SNES;
      win_addr  = bus.SNES_ADDR;
      win_we    = bus.SNES_WE;
      win_wdata = bus.SNES_WDATA;
    end else if (bus.GSU_REQ && (!bus.MCU_REQ || !rr_mcu_q)) begin
      win_valid = 1'b1;
      win_gnt   = GNT_GSU;
      win_addr  = bus.GSU_ADDR;
      win_we    = bus.GSU_WE;
      win_wdata = bus.GSU_WDATA;
    end else if (bus.MCU_REQ) begin
      win_valid = 1'b1;
      win_gnt   = GNT_MCU;
      win_addr  = bus.MCU_ADDR;
      win_we    = bus.MCU_WE;
      win_wdata = bus.MCU_WDATA;
    end
  end

  assign snes_serving = (state_q != ST_IDLE) && (gnt_q == GNT_SNES);

  // Next-state, SNES pulse latch and next values of the registered outputs.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    cnt_d          = cnt_q;
    rr_mcu_d       = rr_mcu_q;
    snes_pend_d    = snes_pend_q;
    snes_addr_d    = snes_addr_q;
    snes_we_d      = snes_we_q;
    snes_wdata_d   = snes_wdata_q;
    snes_overrun_d = snes_overrun_q;
    mem_addr_d     = mem_addr_q;
    mem_dout_d     = mem_dout_q;
    mem_we_d       = mem_we_q;
    mem_drive_d    = 1'b0;
    mem_oe_n_d     = 1'b1;
    mem_we_n_d     = 1'b1;
    snes_ack_d     = 1'b0;
    gsu_ack_d      = 1'b0;
    mcu_ack_d      = 1'b0;
    snes_rdata_d   = snes_rdata_q;
    gsu_rdata_d    = gsu_rdata_q;
    mcu_rdata_d    = mcu_rdata_q;

    // A pulse is kept only when nothing SNES is already queued or in flight.
    if (bus.SNES_REQ) begin
      if (snes_pend_q || snes_serving) begin
        snes_overrun_d = 1'b1;
      end else begin
        snes_pend_d  = 1'b1;
        snes_addr_d  = bus.SNES_ADDR;
        snes_we_d    = bus.SNES_WE;
        snes_wdata_d = bus.SNES_WDATA;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d    = ST_ACCESS;
          gnt_d      = win_gnt;
          cnt_d      = CNT_LOAD;
          mem_addr_d = win_addr;
          mem_we_d   = win_we;
          mem_dout_d = win_wdata;
          mem_drive_d = win_we;
          mem_oe_n_d  = win_we;
          if (win_gnt == GNT_SNES) begin
            snes_pend_d = 1'b0;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_ACK;
          case (gnt_q)
            GNT_SNES: begin
              snes_ack_d = 1'b1;
              if (!mem_we_q) snes_rdata_d = bus.MEM_DIN;
            end
            GNT_GSU: begin
              gsu_ack_d = 1'b1;
              if (!mem_we_q) gsu_rdata_d = bus.MEM_DIN;
            end
            GNT_MCU: begin
              mcu_ack_d = 1'b1;
              if (!mem_we_q) mcu_rdata_d = bus.MEM_DIN;
            end
            default: ;
          endcase
        end else begin
          cnt_d       = cnt_q - 4'd1;
          mem_drive_d = mem_we_q;
          mem_oe_n_d  = mem_we_q;
          mem_we_n_d  = !(mem_we_q && (cnt_d >= 4'd1) && (cnt_d <= CNT_WE_HI));
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
        if (gnt_q == GNT_GSU) rr_mcu_d = 1'b1;
        if (gnt_q == GNT_MCU) rr_mcu_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.SNES_RDATA   = snes_rdata_q;
  assign bus.SNES_ACK     = snes_ack_q;
  assign bus.GSU_RDATA    = gsu_rdata_q;
  assign bus.GSU_ACK      = gsu_ack_q;
  assign bus.MCU_RDATA    = mcu_rdata_q;
  assign bus.MCU_ACK      = mcu_ack_q;
  assign bus.MEM_ADDR     = mem_addr_q;
  assign bus.MEM_DOUT     = mem_dout_q;
  assign bus.MEM_DRIVE    = mem_drive_q;
  assign bus.MEM_OE_N     = mem_oe_n_q;
  assign bus.MEM_WE_N     = mem_we_n_q;
  assign bus.BUSY         = busy_q;
  assign bus.SNES_OVERRUN = snes_overrun_q;

endmodule

// File: tb/tb_gsu_mem_arbiter.sv
// tb/tb_gsu_mem_arbiter.sv - directed self-checking bench for gsu_mem_arbiter
module tb_gsu_mem_arbiter;
  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_errors;

  gsu_mem_arbiter_if bus();

  gsu_mem_arbiter #(.ACCESS_CYCLES(6)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int oe_cnt;
    int s_at, g_at, m_at, last_at, n_ack, s_acks;
    logic [7:0] seq;
    logic [7:0] drv_mask, wen_mask, oe_mask;

    n_checks = 0;
    n_errors = 0;
    RST_N = 1'b0;
    bus.SNES_REQ = 0; bus.SNES_ADDR = 0; bus.SNES_WE = 0; bus.SNES_WDATA = 0;
    bus.GSU_REQ  = 0; bus.GSU_ADDR  = 0; bus.GSU_WE  = 0; bus.GSU_WDATA  = 0;
    bus.MCU_REQ  = 0; bus.MCU_ADDR  = 0; bus.MCU_WE  = 0; bus.MCU_WDATA  = 0;
    bus.MEM_DIN  = 8'h00;
    repeat (3) step();

    // Reset state
    check("rst_oe_n",  32'(bus.MEM_OE_N), 32'd1);
    check("rst_we_n",  32'(bus.MEM_WE_N), 32'd1);
    check("rst_drive", 32'(bus.MEM_DRIVE), 32'd0);
    check("rst_addr",  32'(bus.MEM_ADDR), 32'd0);
    check("rst_dout",  32'(bus.MEM_DOUT), 32'd0);
    check("rst_busy",  32'(bus.BUSY), 32'd0);
    check("rst_ovr",   32'(bus.SNES_OVERRUN), 32'd0);
    check("rst_acks",  32'({bus.SNES_ACK, bus.GSU_ACK, bus.MCU_ACK}), 32'd0);
    check("rst_rdata", 32'({bus.SNES_RDATA, bus.GSU_RDATA, bus.MCU_RDATA}), 32'd0);
    RST_N = 1'b1;
    step();

    // MCU read 0x0012AB
    bus.MCU_ADDR = 24'h0012AB; bus.MCU_WE = 1'b0; bus.MEM_DIN = 8'h5A; bus.MCU_REQ = 1'b1;
    oe_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k <= 6 && bus.MEM_OE_N == 1'b0) oe_cnt++;
      if (k == 1) check("rd_busy", 32'(bus.BUSY), 32'd1);
      if (k == 3) begin
        check("rd_addr", 32'(bus.MEM_ADDR), 32'h0012AB);
        check("rd_drive", 32'(bus.MEM_DRIVE), 32'd0);
        check("rd_we_n", 32'(bus.MEM_WE_N), 32'd1);
      end
      if (k == 6) check("rd_early_ack", 32'(bus.MCU_ACK), 32'd0);
      if (k == 7) begin
        check("rd_mcu_ack", 32'(bus.MCU_ACK), 32'd1);
        check("rd_other_ack", 32'({bus.SNES_ACK, bus.GSU_ACK}), 32'd0);
        check("rd_mcu_rdata", 32'(bus.MCU_RDATA), 32'h5A);
        check("rd_ack_oe_n", 32'(bus.MEM_OE_N), 32'd1);
        bus.MCU_REQ = 1'b0;
      end
    end
    check("rd_oe_cycles", 32'(oe_cnt), 32'd6);
    step();
    check("rd_ack_one_cycle", 32'(bus.MCU_ACK), 32'd0);
    check("rd_idle_busy", 32'(bus.BUSY), 32'd0);

    // SNES priority over GSU/MCU arriving in the same cycle
    bus.MEM_DIN = 8'h3C;
    bus.SNES_ADDR = 24'h008000; bus.SNES_WE = 1'b0; bus.SNES_REQ = 1'b1;
    bus.GSU_ADDR = 24'h010000;  bus.GSU_WE = 1'b0;  bus.GSU_REQ = 1'b1;
    bus.MCU_ADDR = 24'h020000;  bus.MCU_WE = 1'b0;  bus.MCU_REQ = 1'b1;
    s_at = 0; g_at = 0; m_at = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 1) bus.SNES_REQ = 1'b0;
      if (bus.SNES_ACK && s_at == 0) s_at = k;
      if (bus.GSU_ACK && g_at == 0) begin g_at = k; bus.GSU_REQ = 1'b0; end
      if (bus.MCU_ACK && m_at == 0) begin m_at = k; bus.MCU_REQ = 1'b0; end
    end
    check("pri_snes_at", 32'(s_at), 32'd7);
    check("pri_gsu_at",  32'(g_at), 32'd15);
    check("pri_mcu_at",  32'(m_at), 32'd23);
    check("pri_snes_rdata", 32'(bus.SNES_RDATA), 32'h3C);
    check("pri_ovr", 32'(bus.SNES_OVERRUN), 32'd0);

    // Round-robin with GSU and MCU held continuously
    bus.GSU_REQ = 1'b1; bus.MCU_REQ = 1'b1;
    seq = 8'd0; n_ack = 0; last_at = 0;
    for (int k = 1; k <= 60 && n_ack < 4; k++) begin
      step();
      if (bus.GSU_ACK) begin seq = {seq[5:0], 2'd2}; n_ack++; last_at = k; end
      if (bus.MCU_ACK) begin seq = {seq[5:0], 2'd3}; n_ack++; last_at = k; end
      if (n_ack == 4) begin bus.GSU_REQ = 1'b0; bus.MCU_REQ = 1'b0; end
    end
    bus.GSU_REQ = 1'b0; bus.MCU_REQ = 1'b0;
    check("rr_order", 32'(seq), 32'b10_11_10_11);
    check("rr_last_at", 32'(last_at), 32'd31);
    step(); step();

    // GSU write 0xE00010 <= 0xC3
    bus.MEM_DIN = 8'h99;
    bus.GSU_ADDR = 24'hE00010; bus.GSU_WE = 1'b1; bus.GSU_WDATA = 8'hC3; bus.GSU_REQ = 1'b1;
    drv_mask = 8'd0; wen_mask = 8'd0; oe_mask = 8'd0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (bus.MEM_DRIVE) drv_mask[k] = 1'b1;
      if (!bus.MEM_WE_N) wen_mask[k] = 1'b1;
      if (!bus.MEM_OE_N) oe_mask[k] = 1'b1;
      if (k == 3) begin
        check("wr_addr", 32'(bus.MEM_ADDR), 32'hE00010);
        check("wr_dout", 32'(bus.MEM_DOUT), 32'hC3);
      end
      if (k == 7) begin
        check("wr_gsu_ack", 32'(bus.GSU_ACK), 32'd1);
        bus.GSU_REQ = 1'b0;
      end
    end
    check("wr_drive_mask", 32'(drv_mask), 32'b0111_1110);
    check("wr_we_n_mask",  32'(wen_mask), 32'b0011_1100);
    check("wr_oe_mask",    32'(oe_mask),  32'd0);
    check("wr_rdata_kept", 32'(bus.GSU_RDATA), 32'h3C);
    step();

    // SNES overrun: second pulse while the first is in ACCESS
    bus.MEM_DIN = 8'h77;
    bus.SNES_ADDR = 24'h000100; bus.SNES_WE = 1'b0; bus.SNES_REQ = 1'b1;
    s_acks = 0; s_at = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) bus.SNES_REQ = 1'b0;
      if (k == 3) begin
        check("ovr_before", 32'(bus.SNES_OVERRUN), 32'd0);
        bus.SNES_ADDR = 24'h000200; bus.SNES_REQ = 1'b1;
      end
      if (k == 4) begin
        bus.SNES_REQ = 1'b0;
        check("ovr_set", 32'(bus.SNES_OVERRUN), 32'd1);
      end
      if (bus.SNES_ACK) begin
        s_acks++;
        if (s_at == 0) s_at = k;
      end
    end
    check("ovr_ack_count", 32'(s_acks), 32'd1);
    check("ovr_ack_at", 32'(s_at), 32'd7);
    check("ovr_rdata", 32'(bus.SNES_RDATA), 32'h77);
    check("ovr_sticky", 32'(bus.SNES_OVERRUN), 32'd1);

    // Reset at cnt=2 of a GSU write
    bus.GSU_ADDR = 24'h000055; bus.GSU_WE = 1'b1; bus.GSU_WDATA = 8'hA5; bus.GSU_REQ = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    check("mid_we_n_active", 32'(bus.MEM_WE_N), 32'd0);
    check("mid_busy", 32'(bus.BUSY), 32'd1);
    RST_N = 1'b0;
    step();
    check("abort_we_n",  32'(bus.MEM_WE_N), 32'd1);
    check("abort_drive", 32'(bus.MEM_DRIVE), 32'd0);
    check("abort_oe_n",  32'(bus.MEM_OE_N), 32'd1);
    check("abort_addr",  32'(bus.MEM_ADDR), 32'd0);
    check("abort_dout",  32'(bus.MEM_DOUT), 32'd0);
    check("abort_busy",  32'(bus.BUSY), 32'd0);
    check("abort_ovr",   32'(bus.SNES_OVERRUN), 32'd0);
    check("abort_rdata", 32'({bus.SNES_RDATA, bus.GSU_RDATA, bus.MCU_RDATA}), 32'd0);
    RST_N = 1'b1;
    bus.GSU_REQ = 1'b0;
    n_ack = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.GSU_ACK || bus.SNES_ACK || bus.MCU_ACK) n_ack++;
    end
    check("abort_no_ack", 32'(n_ack), 32'd0);
    check("abort_idle_busy", 32'(bus.BUSY), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/gsu_mem_arbiter.md
# gsu_mem_arbiter

Single-port memory arbiter for the shared ROM/SaveRAM chip in the GSU build. It shares one memory port between three requesters: the SNES bus, the GSU core and the MCU. Each requester supplies an already-translated 24-bit ROM/SaveRAM address from the address decoder. The block serialises accesses and generates the memory strobes with a fixed access length. SNES accesses have priority so that SNES bus timing is met; GSU and MCU share the remaining bandwidth round-robin.

## Interface
- ACCESS_CYCLES, 6: memory strobe length in CLK cycles; legal range 3..15.
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- SNES_REQ  in  1  one-cycle request pulse.
- SNES_ADDR  in  24  translated address.
- SNES_WE  in  1  1 = write.
- SNES_WDATA  in  8  write data.
- SNES_RDATA  out  8  read data.
- SNES_ACK  out  1  one-cycle completion pulse.
- GSU_REQ, GSU_ADDR[23:0], GSU_WE, GSU_WDATA[7:0]  in  GSU request; REQ is level-held until ACK.
- GSU_RDATA[7:0], GSU_ACK  out  GSU response.
- MCU_REQ, MCU_ADDR[23:0], MCU_WE, MCU_WDATA[7:0]  in  MCU request; same protocol as GSU.
- MCU_RDATA[7:0], MCU_ACK  out  MCU response.
- MEM_ADDR  out  24  memory address.
- MEM_DOUT  out  8  write data.
- MEM_DRIVE  out  1  data bus output enable.
- MEM_OE_N  out  1  memory output enable, active low.
- MEM_WE_N  out  1  memory write enable, active low.
- MEM_DIN  in  8  memory read data.
- BUSY  out  1  high in ACCESS and ACK states.
- SNES_OVERRUN  out  1  sticky flag: an SNES pulse was dropped.

## Operation
- FSM states: IDLE, ACCESS, ACK.
- Registered 4-bit counter `cnt` and 2-bit grant `gnt` (values NONE, SNES, GSU, MCU).
- SNES pulse latch:
  - A SNES_REQ pulse stores addr/we/wdata and sets `snes_pend`.
  - A pulse arriving while `snes_pend` is set or SNES is being served is dropped and sets SNES_OVERRUN.
  - `snes_pend` clears when SNES is granted.
- IDLE arbitration uses pending SNES, including a pulse arriving this same cycle; that pulse is granted directly.
  - Priority: SNES first, then GSU/MCU by round-robin.
  - Round-robin bit `rr_mcu`: 0 prefers GSU, 1 prefers MCU. After GSU is served it becomes 1; after MCU is served it becomes 0. A lone requester always wins.
  - On a winner: latch its addr/we/wdata into the MEM_* registers, set cnt=ACCESS_CYCLES-1, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - MEM_ADDR stays stable throughout.
  - Read: MEM_OE_N=0 for all ACCESS cycles, MEM_DRIVE=0.
  - Write: MEM_DRIVE=1 and MEM_DOUT valid for all ACCESS cycles; MEM_WE_N=0 only for cnt in ACCESS_CYCLES-2 down to 1, giving one cycle of setup and one of hold.
  - cnt decrements each cycle. At cnt==0, a read captures MEM_DIN into the winner's RDATA register; then go to ACK.
- ACK:
  - Winner's ACK=1 for exactly one cycle; all strobes inactive (OE_N=1, WE_N=1, DRIVE=0).
  - Update `rr_mcu`, go to IDLE.
- RDATA of each requester holds until that requester's next completed read. Writes leave RDATA unchanged.
- GSU/MCU must drop REQ no later than their ACK cycle. REQ still high in the following IDLE cycle is a new request.
- Reset mid-access aborts immediately: no ACK, `snes_pend` cleared, memory strobes inactive in the next cycle.

## Timing
- Reset values: state IDLE, gnt NONE, cnt 0, rr_mcu 0, every *_ACK 0, every *_RDATA 0x00, MEM_ADDR 0, MEM_DOUT 0, MEM_DRIVE 0, MEM_OE_N 1, MEM_WE_N 1, BUSY 0, SNES_OVERRUN 0.
- Grant is decided in IDLE cycle t. Strobes are driven from t+1 through t+ACCESS_CYCLES. ACK is asserted at t+ACCESS_CYCLES+1.
- With the default parameter, latency is 7 cycles from request to ACK.
- Throughput is one access per ACCESS_CYCLES+2 cycles: back-to-back accesses are separated by one IDLE cycle.
- Worst-case SNES wait is one in-flight access plus its own: 2×(ACCESS_CYCLES+2) cycles = 16 cycles at default.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Read: after reset, MCU read of 0x0012AB with MEM_DIN=0x5A → MEM_OE_N low for cycles t+1..t+6, MCU_ACK at t+7, MCU_RDATA=0x5A; GSU_ACK and SNES_ACK stay 0.
- Write: GSU write 0xE00010 data 0xC3 → MEM_DRIVE high for 6 cycles, MEM_WE_N low for exactly 4 cycles (t+2..t+5), GSU_RDATA unchanged.
- SNES priority: SNES_REQ pulse in the same cycle as GSU_REQ, and MCU_REQ held → SNES served first, then GSU, then MCU (order SNES, GSU, MCU; each ACK 8 cycles apart).
- Round-robin: GSU and MCU both held, re-requesting after each ACK → grants alternate GSU, MCU, GSU, MCU; no starvation.
- Overrun: second SNES_REQ pulse during SNES ACCESS → dropped, SNES_OVERRUN=1 and stays set, only one SNES_ACK.
- Reset: RST_N=0 at cnt=2 of a write → next cycle MEM_WE_N=1, MEM_DRIVE=0, no ACK, and all outputs at their reset values.
